chunked_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor, the next-generation arithmetic block after the fixed 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, rippling the carry between slices in a register, which trades latency for a short combinational path. The block sits between a requester issuing START pulses and a consumer reading registered results with flags on DONE.

---
 rtl/chunked_addsub.sv | 141 ++++++++++++++
 tb/tb_chunked_addsub.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle chunked adder/subtractor
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk
// first, keeping the inter-chunk carry in a register. One operation takes
// N = WIDTH/CHUNK RUN cycles followed by a single DONE cycle.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - operation request, honoured only in IDLE
//   mode      - 0 = add, 1 = subtract
//   cin       - carry-in (add) / borrow-in (subtract)
//   a, b      - operands, sampled on the capture edge only
//   busy      - high while chunks are being processed
//   done      - one-cycle pulse, results freshly valid
//   sum       - registered result
//   carry     - raw MSB carry-out (subtract: 1 = no borrow)
//   overflow  - two's-complement signed overflow
//   zero      - sum == 0

module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already inverted for subtract
    logic [WIDTH-1:0] work_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] work_next;
    logic             last_chunk;

    // Datapath for the chunk selected by idx. work_next is the working
    // register with this cycle's slice merged in, so the completion edge can
    // load the final result without an extra cycle.
    always_comb begin
        a_slice    = a_reg[idx*CHUNK +: CHUNK];
        b_slice    = b_reg[idx*CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_reg};
        work_next  = work_reg;
        work_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last_chunk = (idx == LAST_IDX);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_chunk) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + ~borrow, so the adder path is shared.
                        a_reg     <= a;
                        b_reg     <= mode ? ~b : b;
                        carry_reg <= mode ? ~cin : cin;
                        work_reg  <= '0;
                        idx       <= '0;
                    end
                end
                ST_RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        idx      <= '0;
                        sum      <= work_next;
                        carry    <= chunk_sum[CHUNK];
                        overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (work_next[WIDTH-1] != a_reg[WIDTH-1]);
                        zero     <= (work_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pure state decodes; no combinational path from inputs.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_chunked_addsub.sv
// tb/tb_chunked_addsub.sv - self-checking bench for chunked_addsub

module tb_chunked_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start4 = 1'b0;
    logic        start16 = 1'b0;
    logic        mode = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        busy4, done4, carry4, ovf4, zero4;
    logic [15:0] sum4;
    logic        busy16, done16, carry16, ovf16, zero16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } res_t;

    res_t held [2];
    res_t exp_r;
    res_t q [$];

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .cin(cin),
        .a(a), .b(b), .busy(busy4), .done(done4), .sum(sum4),
        .carry(carry4), .overflow(ovf4), .zero(zero4)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .cin(cin),
        .a(a), .b(b), .busy(busy16), .done(done16), .sum(sum16),
        .carry(carry16), .overflow(ovf16), .zero(zero16)
    );

    // Reference: integer arithmetic straight from the add/subtract definitions.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mm, input logic mc);
        res_t r;
        int ua, ub, sa, sb, u, s;
        logic [31:0] ubits;
        ua = int'({16'd0, ma});
        ub = int'({16'd0, mb});
        sa = int'($signed({{16{ma[15]}}, ma}));
        sb = int'($signed({{16{mb[15]}}, mb}));
        if (!mm) begin
            u = ua + ub + int'(mc);
            s = sa + sb + int'(mc);
            r.carry = (u >= 65536);
        end else begin
            u = ua - ub - int'(mc);
            s = sa - sb - int'(mc);
            r.carry = (u >= 0);
        end
        ubits  = u;
        r.sum  = ubits[15:0];
        r.ovf  = (s > 32767) || (s < -32768);
        r.zero = (r.sum == 16'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic o_busy(input int sel);
        return sel != 0 ? busy16 : busy4;
    endfunction
    function automatic logic o_done(input int sel);
        return sel != 0 ? done16 : done4;
    endfunction
    function automatic res_t o_res(input int sel);
        res_t r;
        r.sum   = sel != 0 ? sum16 : sum4;
        r.carry = sel != 0 ? carry16 : carry4;
        r.ovf   = sel != 0 ? ovf16 : ovf4;
        r.zero  = sel != 0 ? zero16 : zero4;
        return r;
    endfunction

    task automatic scramble();
        a    = 16'($urandom);
        b    = 16'($urandom);
        mode = 1'($urandom);
        cin  = 1'($urandom);
    endtask

    // Called at posedge+1 with the selected DUT idle.
    task automatic run_op(input int sel, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tm, input logic tc, input string tag);
        int   n;
        res_t e;
        res_t o;
        n = (sel != 0) ? 1 : 4;
        e = model(ta, tb_v, tm, tc);
        a = ta; b = tb_v; mode = tm; cin = tc;
        if (sel != 0) start16 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start16 = 1'b0;
        scramble();
        for (int i = 0; i < n; i++) begin
            o = o_res(sel);
            chk({tag, " busy"}, 32'(o_busy(sel)), 32'd1);
            chk({tag, " done_early"}, 32'(o_done(sel)), 32'd0);
            chk({tag, " sum_hold"}, 32'(o.sum), 32'(held[sel].sum));
            @(posedge clk); #1;
        end
        o = o_res(sel);
        chk({tag, " done"}, 32'(o_done(sel)), 32'd1);
        chk({tag, " busy_at_done"}, 32'(o_busy(sel)), 32'd0);
        chk({tag, " sum"}, 32'(o.sum), 32'(e.sum));
        chk({tag, " carry"}, 32'(o.carry), 32'(e.carry));
        chk({tag, " ovf"}, 32'(o.ovf), 32'(e.ovf));
        chk({tag, " zero"}, 32'(o.zero), 32'(e.zero));
        held[sel] = e;
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 32'(o_done(sel)), 32'd0);
        chk({tag, " idle"}, 32'(o_busy(sel)), 32'd0);
    endtask

    initial begin
        held[0] = '0;
        held[1] = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst done", 32'(done4), 32'd0);
        chk("rst sum", 32'(sum4), 32'd0);
        chk("rst flags", {29'd0, carry4, ovf4, zero4}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "add1");
        chk("add1 lit sum", 32'(sum4), 32'h2233);
        chk("add1 lit flags", {29'd0, carry4, ovf4, zero4}, 32'd0);

        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
        chk("add_wrap lit sum", 32'(sum4), 32'h0000);
        chk("add_wrap lit flags", {29'd0, carry4, ovf4, zero4}, 32'b101);

        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");
        chk("sub_ovf lit sum", 32'(sum4), 32'h7FFF);
        chk("sub_ovf lit flags", {29'd0, carry4, ovf4, zero4}, 32'b110);

        run_op(0, 16'h0003, 16'h0005, 1'b1, 1'b1, "sub_borrow");
        chk("sub_borrow lit sum", 32'(sum4), 32'hFFFD);
        chk("sub_borrow lit flags", {29'd0, carry4, ovf4, zero4}, 32'b000);

        // Random operations
        for (int i = 0; i < 12; i++) begin
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        // START held high, inputs changing every cycle
        scramble();
        start4 = 1'b1;
        for (int t = 0; t < 18; t++) begin
            if (t % 6 == 0) q.push_back(model(a, b, mode, cin));
            @(posedge clk); #1;
            if (t % 6 == 4) begin
                exp_r = q.pop_front();
                chk("cont done", 32'(done4), 32'd1);
                chk("cont sum", 32'(sum4), 32'(exp_r.sum));
                chk("cont flags", {29'd0, carry4, ovf4, zero4},
                    {29'd0, exp_r.carry, exp_r.ovf, exp_r.zero});
                held[0] = exp_r;
            end else begin
                chk("cont no_done", 32'(done4), 32'd0);
                chk("cont sum_hold", 32'(sum4), 32'(held[0].sum));
            end
            chk("cont busy", 32'(busy4), (t % 6 < 4) ? 32'd1 : 32'd0);
            scramble();
        end
        start4 = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of RUN
        a = 16'h7777; b = 16'h1111; mode = 1'b0; cin = 1'b0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy4), 32'd0);
        chk("midrst done", 32'(done4), 32'd0);
        chk("midrst sum", 32'(sum4), 32'd0);
        chk("midrst flags", {29'd0, carry4, ovf4, zero4}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        held[0] = '0;
        held[1] = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("postrst no_done", 32'(done4), 32'd0);
            chk("postrst no_busy", 32'(busy4), 32'd0);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, "postrst_add");
        chk("postrst lit sum", 32'(sum4), 32'h0002);

        // Single-chunk configuration
        run_op(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "c16_add1");
        chk("c16 lit sum", 32'(sum16), 32'h2233);
        chk("c16 lit flags", {29'd0, carry16, ovf16, zero16}, 32'd0);
        run_op(1, 16'h8000, 16'h0001, 1'b1, 1'b0, "c16_sub");
        for (int i = 0; i < 4; i++) begin
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "c16_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
